reg_write_arbiter: RTL
======================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the register address width (32 registers).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  clock, all state on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 hold  input  1  pipeline freeze; when 1, no request is granted.
REQ-006 wb0_valid  input  1  ALU writeback request; wb0_addr  input  ADDR_W  destination register; wb0_data  input  DATA_W  write value.
REQ-007 wb1_valid  input  1  load writeback request; wb1_addr  input  ADDR_W  destination register; wb1_data  input  DATA_W  write value.
REQ-008 wb0_ready, wb1_ready  output  1 each  request accepted this cycle (combinational).
REQ-009 regwrite  output  1  register-bank write enable (registered).
REQ-010 wreg  output  ADDR_W  register-bank write address (registered).
REQ-011 WriteData  output  DATA_W  register-bank write data (registered).
REQ-012 conflict_cnt  output  16  saturating count of cycles in which both requesters contended.

Function
REQ-013 A transfer on requester n SHALL occur in a cycle where wbn_valid=1 and wbn_ready=1 at the rising clk edge.
REQ-014 A requester SHALL hold valid, addr and data stable until its transfer; the arbiter SHALL NOT depend on this for correctness beyond sampling at the transfer edge.
REQ-015 When hold=1, wb0_ready and wb1_ready SHALL both be 0 regardless of valid inputs.
REQ-016 When hold=0 and exactly one valid is 1, that requester's ready SHALL be 1 and the other 0.
REQ-017 When hold=0 and both valids are 1, ready SHALL go only to the requester selected by the 1-bit priority register prio (0 = wb0 first, 1 = wb1 first).
REQ-018 After every transfer, prio SHALL be set to the index of the requester that was NOT granted; with no transfer, prio SHALL hold.
REQ-019 Ready SHALL never be 1 on both requesters in the same cycle, and ready SHALL never be 1 on a requester whose valid is 0.
REQ-020 On the edge of a transfer with addr != 0, the block SHALL load wreg/WriteData with the granted addr/data and set regwrite=1 for the next cycle only (latency 1 cycle).
REQ-021 A transfer with addr = 0 SHALL be accepted (ready=1) but SHALL leave regwrite=0 and SHALL NOT change wreg or WriteData.
REQ-022 In any cycle following an edge with no transfer (or an addr-0 transfer), regwrite SHALL be 0 and wreg/WriteData SHALL hold their previous values.
REQ-023 Back-to-back transfers on consecutive cycles SHALL produce regwrite=1 on consecutive cycles with the corresponding addresses in order.
REQ-024 conflict_cnt SHALL increment by 1 on each edge where hold=0, wb0_valid=1 and wb1_valid=1, and SHALL saturate at 0xFFFF without wrapping.
REQ-025 hold=1 cycles SHALL NOT increment conflict_cnt and SHALL NOT change prio.

Reset
REQ-026 While rst_n=0, regwrite SHALL be 0, wreg 0, WriteData 0, prio 0, conflict_cnt 0, immediately and independent of clk.
REQ-027 While rst_n=0, wb0_ready and wb1_ready SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight write: regwrite SHALL drop to 0 asynchronously and no write SHALL appear after deassertion unless a new transfer occurs.
REQ-029 The first transfer after rst_n deasserts SHALL be granted per prio=0 (wb0 wins a tie).

Verification
REQ-030 Single request: wb1_valid=1, addr=7, data=0x0000_00B2, hold=0 -> wb1_ready=1 that cycle; next cycle regwrite=1, wreg=7, WriteData=0x0000_00B2; following cycle regwrite=0.
REQ-031 Contention: both valid for 4 cycles (wb0 addr 1..., wb1 addr 2...) after reset -> grants alternate wb0, wb1, wb0, wb1; conflict_cnt=4 (each requester holds valid until served, and a new request is presented after each grant).
REQ-032 Zero register: wb0_valid=1, addr=0, data=0xFFFF_FFFF -> wb0_ready=1; next cycle regwrite=0, wreg/WriteData unchanged; prio becomes 1.
REQ-033 Hold: both valid, hold=1 for 3 cycles then 0 -> no ready and no regwrite during hold, conflict_cnt and prio unchanged; grant to prio winner on first cycle after release.
REQ-034 Saturation: force 0x10000+ contention cycles -> conflict_cnt stops at 0xFFFF.
REQ-035 Async reset: assert rst_n=0 mid-cycle while regwrite=1 -> regwrite, wreg, WriteData, conflict_cnt go to 0 before the next clk edge; after release, tie grants wb0.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Writeback request bundle for two requesters (wb0 = ALU, wb1 = load)
// feeding the register-write arbiter.
interface reg_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wb0_valid;
   logic [ADDR_W-1:0] wb0_addr;
   logic [DATA_W-1:0] wb0_data;
   logic              wb0_ready;
   logic              wb1_valid;
   logic [ADDR_W-1:0] wb1_addr;
   logic [DATA_W-1:0] wb1_data;
   logic              wb1_ready;

   // Requester side: presents requests, observes acceptance
   modport master (
      output wb0_valid, wb0_addr, wb0_data,
      input  wb0_ready,
      output wb1_valid, wb1_addr, wb1_data,
      input  wb1_ready
   );

   // Arbiter side: samples requests, returns acceptance
   modport slave (
      input  wb0_valid, wb0_addr, wb0_data,
      output wb0_ready,
      input  wb1_valid, wb1_addr, wb1_data,
      output wb1_ready
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester register-bank write arbiter. Round-robin on contention
// (the loser of a transfer gets priority next), registered write port,
// writes to register 0 are accepted but discarded, and a saturating
// counter of contended cycles.
module reg_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hold,
   reg_write_arbiter_if.slave  wb,
   output logic                regwrite,
   output logic [ADDR_W-1:0]   wreg,
   output logic [DATA_W-1:0]   WriteData,
   output logic [15:0]         conflict_cnt
);

   logic              prio_q, prio_d;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [15:0]       cnt_q, cnt_d;

   logic              ready0_s, ready1_s;
   logic              contend_s;
   logic              xfer_s;
   logic [ADDR_W-1:0] gaddr_s;
   logic [DATA_W-1:0] gdata_s;

   // Grant decode: nothing is accepted in reset or while frozen; on a tie
   // the priority bit picks the winner, so both readies are never high
   always_comb begin
      ready0_s  = 1'b0;
      ready1_s  = 1'b0;
      contend_s = 1'b0;
      if (rst_n && !hold) begin
         contend_s = wb.wb0_valid & wb.wb1_valid;
         ready0_s  = wb.wb0_valid & (~wb.wb1_valid | ~prio_q);
         ready1_s  = wb.wb1_valid & (~wb.wb0_valid |  prio_q);
      end else begin
         contend_s = 1'b0;
         ready0_s  = 1'b0;
         ready1_s  = 1'b0;
      end
   end

   assign wb.wb0_ready = ready0_s;
   assign wb.wb1_ready = ready1_s;

   // Next-state: select the granted payload, skip register 0, rotate
   // priority to the requester that lost, count contention with saturation
   always_comb begin
      xfer_s     = ready0_s | ready1_s;
      gaddr_s    = {ADDR_W{1'b0}};
      gdata_s    = {DATA_W{1'b0}};
      prio_d     = prio_q;
      regwrite_d = 1'b0;
      wreg_d     = wreg_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;

      if (ready1_s) begin
         gaddr_s = wb.wb1_addr;
         gdata_s = wb.wb1_data;
         prio_d  = 1'b0;
      end else if (ready0_s) begin
         gaddr_s = wb.wb0_addr;
         gdata_s = wb.wb0_data;
         prio_d  = 1'b1;
      end else begin
         prio_d  = prio_q;
      end

      if (xfer_s && (gaddr_s != {ADDR_W{1'b0}})) begin
         regwrite_d = 1'b1;
         wreg_d     = gaddr_s;
         wdata_d    = gdata_s;
      end else begin
         regwrite_d = 1'b0;
      end

      if (contend_s && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers; reset clears any in-flight write immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q     <= 1'b0;
         regwrite_q <= 1'b0;
         wreg_q     <= {ADDR_W{1'b0}};
         wdata_q    <= {DATA_W{1'b0}};
         cnt_q      <= 16'd0;
      end else begin
         prio_q     <= prio_d;
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
      end
   end

   assign regwrite     = regwrite_q;
   assign wreg         = wreg_q;
   assign WriteData    = wdata_q;
   assign conflict_cnt = cnt_q;

endmodule
